// File: rtl/defaulting_channel_bank_pkg.sv
// Shared types and helpers for the defaulting channel bank.
// Channel FSM encoding plus the idle-counter width calculation.
package defaulting_channel_bank_pkg;

  typedef enum logic {
    DFLT = 1'b0,
    LIVE = 1'b1
  } chan_state_t;

  // A TIMEOUT of 0 still needs a 1-bit counter so the port widths stay legal.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/defaulting_channel_bank_channel.sv
// One channel: holds the last sampled value and reverts to a default after idling.
// Optional timeout event counter is enabled by DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN.
module defaulting_channel
  import defaulting_channel_bank_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEFAULT_VALUE = 123,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_live,
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
  output logic [7:0]       timeout_count,
`endif
  output logic             timeout_pulse
);

  localparam int unsigned    CW   = cnt_width(TIMEOUT);
  localparam logic [WIDTH-1:0] DV = WIDTH'(DEFAULT_VALUE);
  localparam logic [CW-1:0]  LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  chan_state_t      state_q, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             pulse_q, pulse_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DFLT;
      data_q  <= DV;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      cnt_q   <= cnt_n;
      pulse_q <= pulse_n;
    end
  end

  // Priority: clr, then a fresh sample, then idle ageing of a live channel.
  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    pulse_n = 1'b0;
    if (clr) begin
      state_n = DFLT;
      data_n  = DV;
      cnt_n   = '0;
    end else if (in_valid) begin
      state_n = LIVE;
      data_n  = in_data;
      cnt_n   = '0;
    end else if (state_q == LIVE && TIMEOUT != 0) begin
      if (cnt_q == LAST) begin
        state_n = DFLT;
        data_n  = DV;
        cnt_n   = '0;
        pulse_n = 1'b1;
      end else begin
        cnt_n = cnt_q + CW'(1);
      end
    end
  end

  assign out_data      = data_q;
  assign out_live      = (state_q == LIVE);
  assign timeout_pulse = pulse_q;

`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
  logic [7:0] evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else if (clr) begin
      evt_q <= '0;
    end else if (pulse_n && evt_q != '1) begin
      evt_q <= evt_q + 8'd1;
    end
  end

  assign timeout_count = evt_q;
`endif

endmodule

// File: rtl/defaulting_channel_bank.sv
// Bank of independent defaulting channels; packs per-channel ports into flat buses.
// Define DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN to expose per-channel timeout counts.
module defaulting_channel_bank
  import defaulting_channel_bank_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DEFAULT_VALUE = 123,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_live,
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
  output logic [CHANNELS*8-1:0]     timeout_count,
`endif
  output logic [CHANNELS-1:0]       timeout_pulse
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    defaulting_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_VALUE (DEFAULT_VALUE),
      .TIMEOUT       (TIMEOUT)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .clr           (clr),
      .in_data       (in_data[g*WIDTH +: WIDTH]),
      .in_valid      (in_valid[g]),
      .out_data      (out_data[g*WIDTH +: WIDTH]),
      .out_live      (out_live[g]),
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
      .timeout_count (timeout_count[g*8 +: 8]),
`endif
      .timeout_pulse (timeout_pulse[g])
    );
  end

endmodule

// File: tb/tb_defaulting_channel_bank.sv
// Scoreboard bench for defaulting_channel_bank (default parameters).
// Define DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN to also exercise timeout_count.
module tb_defaulting_channel_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned TO = 15;
  localparam logic [W-1:0] DV = 8'd123;

  logic            clk = 1'b0;
  logic            rst, clr;
  logic [CH*W-1:0] in_data, out_data;
  logic [CH-1:0]   in_valid, out_live, timeout_pulse;
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
  logic [CH*8-1:0] timeout_count;
`endif

  always #5 clk = ~clk;

  defaulting_channel_bank #(
    .WIDTH         (W),
    .CHANNELS      (CH),
    .DEFAULT_VALUE (123),
    .TIMEOUT       (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .out_data      (out_data),
    .out_live      (out_live),
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
    .timeout_count (timeout_count),
`endif
    .timeout_pulse (timeout_pulse)
  );

  typedef struct packed {
    logic [CH*W-1:0] data;
    logic [CH-1:0]   live;
    logic [CH-1:0]   pulse;
    logic [CH*8-1:0] tc;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [W-1:0] m_data[CH];
  bit           m_live[CH];
  int unsigned  m_age[CH];
  int unsigned  m_tc[CH];
  int unsigned  obs_pulse[CH];
  int unsigned  live_cycles0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_data[i] = DV;
      m_live[i] = 0;
      m_age[i]  = 0;
      m_tc[i]   = 0;
    end
  endtask

  // Age counts idle edges since the last sample; the channel expires when it reaches TO.
  task automatic step();
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      bit p;
      p = 0;
      if (clr) begin
        m_live[i] = 0; m_data[i] = DV; m_age[i] = 0; m_tc[i] = 0;
      end else if (in_valid[i]) begin
        m_live[i] = 1; m_data[i] = in_data[i*W +: W]; m_age[i] = 0;
      end else if (m_live[i] && TO > 0) begin
        m_age[i]++;
        if (m_age[i] == TO) begin
          m_live[i] = 0; m_data[i] = DV; m_age[i] = 0; p = 1;
          if (m_tc[i] < 255) m_tc[i]++;
        end
      end
      e.data[i*W +: W] = m_data[i];
      e.live[i]        = m_live[i];
      e.pulse[i]       = p;
      e.tc[i*8 +: 8]   = 8'(m_tc[i]);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("out_data", out_data, e.data);
    chk("out_live", out_live, e.live);
    chk("timeout_pulse", timeout_pulse, e.pulse);
`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
    chk("timeout_count", timeout_count, e.tc);
`endif
    for (int i = 0; i < CH; i++) obs_pulse[i] += timeout_pulse[i];
    live_cycles0 += out_live[0];
  endtask

  task automatic idle(input int unsigned n);
    in_valid = '0;
    clr      = 1'b0;
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  task automatic load(input int unsigned ch, input logic [W-1:0] d);
    in_valid     = '0;
    in_valid[ch] = 1'b1;
    in_data[ch*W +: W] = d;
    step();
    in_valid = '0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < CH; i++) obs_pulse[i] = 0;
    live_cycles0 = 0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = '0; in_data = '0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", out_data, {CH{DV}});
    chk("rst_live", out_live, '0);
    chk("rst_pulse", timeout_pulse, '0);
    rst = 1'b0;

    // Quiet bank after reset stays at default.
    idle(100);
    chk("quiet_pulses", obs_pulse[0] + obs_pulse[1] + obs_pulse[2] + obs_pulse[3], 0);

    // Channel 0: single sample, then idle through the timeout.
    clear_obs();
    load(0, 8'h5A);
    idle(20);
    chk("ch0_pulses", obs_pulse[0], 1);
    chk("ch0_live_cycles", live_cycles0, 15);

    // Channel 1 refreshed every 14 cycles never expires.
    clear_obs();
    for (int p = 0; p < 5; p++) begin
      load(1, 8'(8'h10 + p));
      idle(13);
      chk("ch1_live", out_live[1], 1);
    end
    chk("ch1_pulses", obs_pulse[1], 0);
    idle(20);

    // Channel 2: sample arrives exactly on the expiry edge.
    clear_obs();
    load(2, 8'h33);
    idle(14);
    load(2, 8'hC4);
    chk("ch2_reload_data", out_data[2*W +: W], 8'hC4);
    chk("ch2_reload_pulses", obs_pulse[2], 0);
    // Same edge with clr asserted: clear wins and no pulse.
    idle(14);
    in_valid = 4'b0100; in_data[2*W +: W] = 8'h77; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = '0;
    chk("ch2_clr_live", out_live[2], 0);
    chk("ch2_clr_pulses", obs_pulse[2], 0);
    idle(3);

    // Channel 3: asynchronous reset in the middle of a count.
    load(3, 8'hE1);
    idle(6);
    rst = 1'b1;
    #1;
    chk("arst_data3", out_data[3*W +: W], DV);
    chk("arst_live3", out_live[3], 0);
    chk("arst_pulse", timeout_pulse, '0);
    #1;
    rst = 1'b0;
    model_reset();
    idle(20);

    // Random traffic across all channels with occasional clears.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        in_valid[i] = ($urandom_range(0, 11) == 0);
        in_data[i*W +: W] = 8'($urandom);
      end
      clr = ($urandom_range(0, 60) == 0);
      step();
    end
    idle(20);

`ifdef DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN
    for (int n = 0; n < 300; n++) begin
      load(0, 8'(n));
      idle(15);
    end
    chk("tc0_saturated", timeout_count[7:0], 8'd255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("tc0_cleared", timeout_count[7:0], 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/defaulting_channel_bank.md
DEFAULTING_CHANNEL_BANK -- requirements
Module: defaulting_channel_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of each channel.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent channels (range 1..16).
REQ-003 Parameter DEFAULT_VALUE, default 123, SHALL set the value presented on a channel that has no live data.
REQ-004 Parameter TIMEOUT, default 15, SHALL set the number of idle cycles before a channel reverts to DEFAULT_VALUE; 0 disables timeout.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007 clr  input  1  SHALL be a synchronous clear forcing all channels to default.
REQ-008 in_data  input  CHANNELS*WIDTH  SHALL carry channel data; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  SHALL qualify in_data per channel.
REQ-010 out_data  output  CHANNELS*WIDTH  SHALL carry the registered per-channel value, same packing as in_data.
REQ-011 out_live  output  CHANNELS  SHALL indicate the channel holds sampled data rather than DEFAULT_VALUE.
REQ-012 timeout_pulse  output  CHANNELS  SHALL pulse high for one cycle when a channel times out.

Function
REQ-013 Each channel SHALL implement a state machine with states DFLT, LIVE; DFLT is the reset state.
REQ-014 in_valid[n]=1 in any state SHALL load in_data[n] into out_data[n], set state LIVE and zero its idle counter; visible on out_data one cycle later.
REQ-015 In LIVE with in_valid[n]=0 the idle counter SHALL increment by 1 per cycle; width $clog2(TIMEOUT+1), no wrap.
REQ-016 When the idle counter equals TIMEOUT-1 and in_valid[n]=0, the next edge SHALL set state DFLT, out_data[n]=DEFAULT_VALUE, out_live[n]=0, timeout_pulse[n]=1 for exactly that cycle.
REQ-017 in_valid[n]=1 on the cycle timeout would fire SHALL win: no pulse, data loaded, counter zeroed.
REQ-018 With TIMEOUT=0 the counter SHALL stay zero and a LIVE channel SHALL never revert except via clr or rst.
REQ-019 In DFLT, out_data[n] SHALL equal DEFAULT_VALUE truncated to WIDTH bits and the counter SHALL hold at zero.
REQ-020 clr=1 SHALL win over in_valid: all channels to DFLT, counters zeroed, no timeout_pulse.
REQ-021 out_live[n] SHALL be 1 exactly when channel n is in LIVE.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-023 rst=1 SHALL immediately, without clock, set all channels to DFLT: out_data=DEFAULT_VALUE per channel, out_live=0, timeout_pulse=0, counters 0.
REQ-024 Reset asserted mid-count SHALL discard the count; after release the channel behaves as freshly reset.

Configuration
REQ-025 With macro DEFAULTING_CHANNEL_BANK_EVENT_COUNT_EN defined, output timeout_count (CHANNELS*8 bits) SHALL appear, holding a per-channel 8-bit saturating (stops at 255) count of timeout_pulse events, cleared by rst and clr.
REQ-026 Without the macro the port and counters SHALL be absent and all other behaviour identical.

Structure
REQ-027 Channel state enum (DFLT, LIVE) and the counter-width function SHALL live in shared package defaulting_channel_bank_pkg.
REQ-028 Per-channel logic SHALL be a sub-module defaulting_channel, instantiated CHANNELS times by a generate loop; the top holds only packing and the clr/rst fan-out.

Verification
REQ-029 Reset release, no valid -> out_data all channels =123, out_live=0, no pulses for 100 cycles once channels are in DFLT.
REQ-030 in_valid[0]=1, data 0x5A, then idle -> out_data[0]=0x5A from next cycle for 15 cycles, then 123 with timeout_pulse[0] high one cycle.
REQ-031 Channel 1 valid every 14 cycles -> never times out, out_live[1] stays 1.
REQ-032 Valid on channel 2 exactly at timeout cycle -> no pulse, new data loaded; same cycle clr=1 on another run -> channel 2 DFLT, no pulse.
REQ-033 rst pulsed asynchronously mid-count on LIVE channel 3 -> out_data[3]=123 before next clk edge, out_live[3]=0.
REQ-034 Macro defined, channel 0 timed out 300 times -> timeout_count[7:0]=255; clr -> 0.
